control_pipeline: RTL and testbench

- Sits directly downstream of the Control decoder (opCode -> writeBackControl/memAccessControl/calculationControl).
- Carries each decoded control bundle through the EX, MEM and WB pipeline registers, retiring fields once the stage that uses them has passed.
- Detects load-use hazards, inserts bubbles and applies global stall and flush.
- Also keeps a saturating count of inserted bubbles for debug.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/control_pipeline_hazard_detect.sv | 21 ++
 rtl/control_pipeline.sv | 133 +++++++++++++
 tb/tb_control_pipeline.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-field layout and stage bundle types for the EX/MEM/WB pipeline.
package ctrl_pkg;

  // Control field widths as produced by the decoder
  localparam int WB_W   = 2;
  localparam int MEM_W  = 3;
  localparam int CALC_W = 4;

  // memAccess bit positions
  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_BYTE  = 2;

  // writeBack bit positions
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  // Each stage keeps only the fields still needed downstream.
  // Destination registers live beside these, since their width is a
  // module parameter.
  typedef struct packed {
    logic              valid;
    logic [CALC_W-1:0] calc;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
  } ex_ctrl_t;

  typedef struct packed {
    logic             valid;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [WB_W-1:0] wb;
  } wb_ctrl_t;

endpackage

// File: rtl/control_pipeline_hazard_detect.sv
// Load-use hazard detector: an instruction in ID reads a register that the
// load currently in EX has not produced yet.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idSrcA,
  input  logic [REG_ADDR_W-1:0] idSrcB,
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exDestReg,
  output logic                  hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    hazard = idValid & exValid & exMemRead & (exDestReg != '0) &
             ((exDestReg == idSrcA) | (exDestReg == idSrcB));
  end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control bundles through EX, MEM and WB; handles load-use
// bubbles, global stall and branch flush; counts inserted bubbles.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  idValid,
  input  logic [WB_W-1:0]       idWriteBack,
  input  logic [MEM_W-1:0]      idMemAccess,
  input  logic [CALC_W-1:0]     idCalculation,
  input  logic [REG_ADDR_W-1:0] idDestReg,
  input  logic [REG_ADDR_W-1:0] idSrcA,
  input  logic [REG_ADDR_W-1:0] idSrcB,
  output logic                  exValid,
  output logic [CALC_W-1:0]     exCalculation,
  output logic [MEM_W-1:0]      exMemAccess,
  output logic [WB_W-1:0]       exWriteBack,
  output logic [REG_ADDR_W-1:0] exDestReg,
  output logic                  memValid,
  output logic [MEM_W-1:0]      memMemAccess,
  output logic [WB_W-1:0]       memWriteBack,
  output logic [REG_ADDR_W-1:0] memDestReg,
  output logic                  wbValid,
  output logic [WB_W-1:0]       wbWriteBack,
  output logic [REG_ADDR_W-1:0] wbDestReg,
  output logic                  loadUseStall,
  output logic [CNT_W-1:0]      bubbleCount
);

  ex_ctrl_t              ex_q, ex_d;
  mem_ctrl_t             mem_q, mem_d;
  wb_ctrl_t              wb_q, wb_d;
  logic [REG_ADDR_W-1:0] exDest_q, exDest_d;
  logic [REG_ADDR_W-1:0] memDest_q, memDest_d;
  logic [REG_ADDR_W-1:0] wbDest_q, wbDest_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hazard;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .idValid   (idValid),
    .idSrcA    (idSrcA),
    .idSrcB    (idSrcB),
    .exValid   (ex_q.valid),
    .exMemRead (ex_q.mem[MEM_READ]),
    .exDestReg (exDest_q),
    .hazard    (hazard)
  );

  // A taken branch overrides the hazard: the dependent instruction is squashed anyway
  assign loadUseStall = hazard & ~flush;

  // Next-state selection, priority stall > flush > hazard > normal advance
  always_comb begin
    ex_d      = ex_q;
    exDest_d  = exDest_q;
    mem_d     = mem_q;
    memDest_d = memDest_q;
    wb_d      = wb_q;
    wbDest_d  = wbDest_q;
    cnt_d     = cnt_q;
    if (stall) begin
      // everything holds
    end else if (flush) begin
      // ID and EX entries are squashed; the MEM entry is older and retires normally
      ex_d      = '0;
      exDest_d  = '0;
      mem_d     = '0;
      memDest_d = '0;
      wb_d      = '{valid: mem_q.valid, wb: mem_q.wb};
      wbDest_d  = memDest_q;
    end else begin
      // MEM and WB advance in both the hazard and normal cases
      mem_d     = '{valid: ex_q.valid, mem: ex_q.mem, wb: ex_q.wb};
      memDest_d = exDest_q;
      wb_d      = '{valid: mem_q.valid, wb: mem_q.wb};
      wbDest_d  = memDest_q;
      if (hazard) begin
        ex_d     = '0;
        exDest_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (idValid) begin
        ex_d     = '{valid: 1'b1, calc: idCalculation, mem: idMemAccess, wb: idWriteBack};
        exDest_d = idDestReg;
      end else begin
        // invalid slots carry zero controls so they can never write anything
        ex_d     = '0;
        exDest_d = '0;
      end
    end
  end

  // Stage registers and bubble counter; reset beats stall and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      exDest_q  <= '0;
      mem_q     <= '0;
      memDest_q <= '0;
      wb_q      <= '0;
      wbDest_q  <= '0;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      exDest_q  <= exDest_d;
      mem_q     <= mem_d;
      memDest_q <= memDest_d;
      wb_q      <= wb_d;
      wbDest_q  <= wbDest_d;
      cnt_q     <= cnt_d;
    end
  end

  assign exValid       = ex_q.valid;
  assign exCalculation = ex_q.calc;
  assign exMemAccess   = ex_q.mem;
  assign exWriteBack   = ex_q.wb;
  assign exDestReg     = exDest_q;
  assign memValid      = mem_q.valid;
  assign memMemAccess  = mem_q.mem;
  assign memWriteBack  = mem_q.wb;
  assign memDestReg    = memDest_q;
  assign wbValid       = wb_q.valid;
  assign wbWriteBack   = wb_q.wb;
  assign wbDestReg     = wbDest_q;
  assign bubbleCount   = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline. A second instance with a 3-bit counter
// shares all stimulus so counter saturation is reachable in a few cycles.
module tb_control_pipeline;

  logic clk = 1'b0;
  logic rst, stall, flush, idValid;
  logic [1:0] idWriteBack;
  logic [2:0] idMemAccess;
  logic [3:0] idCalculation;
  logic [4:0] idDestReg, idSrcA, idSrcB;

  logic       exValid, memValid, wbValid, loadUseStall;
  logic [3:0] exCalculation;
  logic [2:0] exMemAccess, memMemAccess;
  logic [1:0] exWriteBack, memWriteBack, wbWriteBack;
  logic [4:0] exDestReg, memDestReg, wbDestReg;
  logic [15:0] bubbleCount;

  logic       s_exValid, s_memValid, s_wbValid, s_loadUseStall;
  logic [3:0] s_exCalculation;
  logic [2:0] s_exMemAccess, s_memMemAccess;
  logic [1:0] s_exWriteBack, s_memWriteBack, s_wbWriteBack;
  logic [4:0] s_exDestReg, s_memDestReg, s_wbDestReg;
  logic [2:0] s_bubbleCount;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_pipeline #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .idValid(idValid),
    .idWriteBack(idWriteBack), .idMemAccess(idMemAccess), .idCalculation(idCalculation),
    .idDestReg(idDestReg), .idSrcA(idSrcA), .idSrcB(idSrcB),
    .exValid(exValid), .exCalculation(exCalculation), .exMemAccess(exMemAccess),
    .exWriteBack(exWriteBack), .exDestReg(exDestReg),
    .memValid(memValid), .memMemAccess(memMemAccess), .memWriteBack(memWriteBack),
    .memDestReg(memDestReg), .wbValid(wbValid), .wbWriteBack(wbWriteBack),
    .wbDestReg(wbDestReg), .loadUseStall(loadUseStall), .bubbleCount(bubbleCount)
  );

  control_pipeline #(.REG_ADDR_W(5), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .idValid(idValid),
    .idWriteBack(idWriteBack), .idMemAccess(idMemAccess), .idCalculation(idCalculation),
    .idDestReg(idDestReg), .idSrcA(idSrcA), .idSrcB(idSrcB),
    .exValid(s_exValid), .exCalculation(s_exCalculation), .exMemAccess(s_exMemAccess),
    .exWriteBack(s_exWriteBack), .exDestReg(s_exDestReg),
    .memValid(s_memValid), .memMemAccess(s_memMemAccess), .memWriteBack(s_memWriteBack),
    .memDestReg(s_memDestReg), .wbValid(s_wbValid), .wbWriteBack(s_wbWriteBack),
    .wbDestReg(s_wbDestReg), .loadUseStall(s_loadUseStall), .bubbleCount(s_bubbleCount)
  );

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                        input logic [3:0] calc, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b);
    idValid = v; idWriteBack = wb; idMemAccess = mem; idCalculation = calc;
    idDestReg = d; idSrcA = a; idSrcB = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 2'b00, 3'b000, 4'h0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 2'b11, 3'b011, 4'hF, 5'd9, 5'd1, 5'd2);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    set_id(1'b0, 2'b00, 3'b000, 4'h0, 5'd0, 5'd0, 5'd0);
    #1;
    n_chk++; if ({exValid, exCalculation, exMemAccess, exWriteBack, exDestReg} !== 15'd0) begin
      n_fail++; $display("FAIL reset_ex got %0h exp 0", {exValid, exCalculation, exMemAccess, exWriteBack, exDestReg}); end
    n_chk++; if ({memValid, memMemAccess, memWriteBack, memDestReg} !== 11'd0) begin
      n_fail++; $display("FAIL reset_mem got %0h exp 0", {memValid, memMemAccess, memWriteBack, memDestReg}); end
    n_chk++; if ({wbValid, wbWriteBack, wbDestReg} !== 8'd0) begin
      n_fail++; $display("FAIL reset_wb got %0h exp 0", {wbValid, wbWriteBack, wbDestReg}); end
    n_chk++; if (bubbleCount !== 16'd0) begin
      n_fail++; $display("FAIL reset_count got %0h exp 0", bubbleCount); end
    n_chk++; if (loadUseStall !== 1'b0) begin
      n_fail++; $display("FAIL reset_luStall got %0b exp 0", loadUseStall); end
  endtask

  task automatic test_straight();
    do_reset();
    set_id(1'b1, 2'b01, 3'b000, 4'b0011, 5'd3, 5'd0, 5'd0);  // A
    tick();
    n_chk++; if ({exValid, exWriteBack, exMemAccess, exCalculation, exDestReg} !== {1'b1, 2'b01, 3'b000, 4'b0011, 5'd3}) begin
      n_fail++; $display("FAIL straight_A_ex got %0h exp %0h", {exValid, exWriteBack, exMemAccess, exCalculation, exDestReg}, {1'b1, 2'b01, 3'b000, 4'b0011, 5'd3}); end
    set_id(1'b1, 2'b11, 3'b001, 4'b0000, 5'd4, 5'd0, 5'd0);  // B
    tick();
    n_chk++; if ({memValid, memWriteBack, memMemAccess, memDestReg} !== {1'b1, 2'b01, 3'b000, 5'd3}) begin
      n_fail++; $display("FAIL straight_A_mem got %0h exp %0h", {memValid, memWriteBack, memMemAccess, memDestReg}, {1'b1, 2'b01, 3'b000, 5'd3}); end
    n_chk++; if ({exValid, exWriteBack, exMemAccess, exDestReg} !== {1'b1, 2'b11, 3'b001, 5'd4}) begin
      n_fail++; $display("FAIL straight_B_ex got %0h exp %0h", {exValid, exWriteBack, exMemAccess, exDestReg}, {1'b1, 2'b11, 3'b001, 5'd4}); end
    // invalid ID with junk fields, sourcing B's dest: must not hazard, must enter as zeros
    set_id(1'b0, 2'b11, 3'b111, 4'hF, 5'd7, 5'd4, 5'd4);
    #1;
    n_chk++; if (loadUseStall !== 1'b0) begin
      n_fail++; $display("FAIL straight_invalid_luStall got %0b exp 0", loadUseStall); end
    tick();
    n_chk++; if ({wbValid, wbWriteBack, wbDestReg} !== {1'b1, 2'b01, 5'd3}) begin
      n_fail++; $display("FAIL straight_A_wb got %0h exp %0h", {wbValid, wbWriteBack, wbDestReg}, {1'b1, 2'b01, 5'd3}); end
    n_chk++; if ({memValid, memWriteBack, memMemAccess, memDestReg} !== {1'b1, 2'b11, 3'b001, 5'd4}) begin
      n_fail++; $display("FAIL straight_B_mem got %0h exp %0h", {memValid, memWriteBack, memMemAccess, memDestReg}, {1'b1, 2'b11, 3'b001, 5'd4}); end
    n_chk++; if ({exValid, exCalculation, exMemAccess, exWriteBack, exDestReg} !== 15'd0) begin
      n_fail++; $display("FAIL straight_invalid_ex got %0h exp 0", {exValid, exCalculation, exMemAccess, exWriteBack, exDestReg}); end
    tick();
    n_chk++; if ({wbValid, wbWriteBack, wbDestReg} !== {1'b1, 2'b11, 5'd4}) begin
      n_fail++; $display("FAIL straight_B_wb got %0h exp %0h", {wbValid, wbWriteBack, wbDestReg}, {1'b1, 2'b11, 5'd4}); end
    n_chk++; if (bubbleCount !== 16'd0) begin
      n_fail++; $display("FAIL straight_count got %0h exp 0", bubbleCount); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 2'b11, 3'b001, 4'h0, 5'd5, 5'd0, 5'd0);  // load r5
    tick();
    set_id(1'b1, 2'b01, 3'b000, 4'b0101, 5'd6, 5'd5, 5'd1);  // uses r5
    #1;
    n_chk++; if (loadUseStall !== 1'b1) begin
      n_fail++; $display("FAIL loaduse_luStall_on got %0b exp 1", loadUseStall); end
    tick();
    n_chk++; if ({exValid, exCalculation, exMemAccess, exWriteBack, exDestReg} !== 15'd0) begin
      n_fail++; $display("FAIL loaduse_bubble got %0h exp 0", {exValid, exCalculation, exMemAccess, exWriteBack, exDestReg}); end
    n_chk++; if ({memValid, memMemAccess, memDestReg} !== {1'b1, 3'b001, 5'd5}) begin
      n_fail++; $display("FAIL loaduse_load_mem got %0h exp %0h", {memValid, memMemAccess, memDestReg}, {1'b1, 3'b001, 5'd5}); end
    n_chk++; if (loadUseStall !== 1'b0) begin
      n_fail++; $display("FAIL loaduse_luStall_off got %0b exp 0", loadUseStall); end
    n_chk++; if (bubbleCount !== 16'd1) begin
      n_fail++; $display("FAIL loaduse_count got %0h exp 1", bubbleCount); end
    tick();
    n_chk++; if ({exValid, exCalculation, exDestReg} !== {1'b1, 4'b0101, 5'd6}) begin
      n_fail++; $display("FAIL loaduse_dep_ex got %0h exp %0h", {exValid, exCalculation, exDestReg}, {1'b1, 4'b0101, 5'd6}); end
    n_chk++; if (bubbleCount !== 16'd1) begin
      n_fail++; $display("FAIL loaduse_count_after got %0h exp 1", bubbleCount); end
  endtask

  task automatic test_dest_zero();
    do_reset();
    set_id(1'b1, 2'b11, 3'b001, 4'h0, 5'd0, 5'd0, 5'd0);  // load to r0
    tick();
    set_id(1'b1, 2'b01, 3'b000, 4'h2, 5'd7, 5'd0, 5'd0);
    #1;
    n_chk++; if (loadUseStall !== 1'b0) begin
      n_fail++; $display("FAIL destzero_luStall got %0b exp 0", loadUseStall); end
    tick();
    n_chk++; if ({exValid, exDestReg} !== {1'b1, 5'd7}) begin
      n_fail++; $display("FAIL destzero_ex got %0h exp %0h", {exValid, exDestReg}, {1'b1, 5'd7}); end
    n_chk++; if (bubbleCount !== 16'd0) begin
      n_fail++; $display("FAIL destzero_count got %0h exp 0", bubbleCount); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1'b1, 2'b01, 3'b000, 4'h1, 5'd2, 5'd0, 5'd0);  // X
    tick();
    set_id(1'b1, 2'b00, 3'b010, 4'h1, 5'd0, 5'd2, 5'd3);  // store
    tick();
    set_id(1'b1, 2'b01, 3'b000, 4'h4, 5'd8, 5'd1, 5'd1);  // Y in ID
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_id(1'b0, 2'b00, 3'b000, 4'h0, 5'd0, 5'd0, 5'd0);
    n_chk++; if ({exValid, exCalculation, exMemAccess, exWriteBack, exDestReg} !== 15'd0) begin
      n_fail++; $display("FAIL flush_ex got %0h exp 0", {exValid, exCalculation, exMemAccess, exWriteBack, exDestReg}); end
    n_chk++; if ({memValid, memMemAccess, memWriteBack, memDestReg} !== 11'd0) begin
      n_fail++; $display("FAIL flush_mem got %0h exp 0", {memValid, memMemAccess, memWriteBack, memDestReg}); end
    n_chk++; if ({wbValid, wbWriteBack, wbDestReg} !== {1'b1, 2'b01, 5'd2}) begin
      n_fail++; $display("FAIL flush_wb got %0h exp %0h", {wbValid, wbWriteBack, wbDestReg}, {1'b1, 2'b01, 5'd2}); end
    n_chk++; if (bubbleCount !== 16'd0) begin
      n_fail++; $display("FAIL flush_count got %0h exp 0", bubbleCount); end
    // flush masks the load-use request to fetch
    set_id(1'b1, 2'b11, 3'b001, 4'h0, 5'd9, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 2'b01, 3'b000, 4'h0, 5'd1, 5'd0, 5'd9);
    flush = 1'b1;
    #1;
    n_chk++; if (loadUseStall !== 1'b0) begin
      n_fail++; $display("FAIL flush_masks_luStall got %0b exp 0", loadUseStall); end
    tick();
    flush = 1'b0;
    n_chk++; if ({exValid, memValid, bubbleCount} !== {1'b0, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL flush_over_hazard got %0h exp 0", {exValid, memValid, bubbleCount}); end
  endtask

  task automatic test_stall_hazard();
    do_reset();
    set_id(1'b1, 2'b01, 3'b000, 4'h3, 5'd2, 5'd0, 5'd0);  // X
    tick();
    set_id(1'b1, 2'b11, 3'b001, 4'h0, 5'd5, 5'd0, 5'd0);  // load r5
    tick();
    set_id(1'b1, 2'b01, 3'b000, 4'h6, 5'd6, 5'd0, 5'd5);  // uses r5 via srcB
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({exValid, exMemAccess, exDestReg, memValid, memDestReg, wbValid, wbDestReg} !== {1'b1, 3'b001, 5'd5, 1'b1, 5'd2, 1'b0, 5'd0}) begin
        n_fail++; $display("FAIL stall_frozen_%0d got %0h exp %0h", i, {exValid, exMemAccess, exDestReg, memValid, memDestReg, wbValid, wbDestReg}, {1'b1, 3'b001, 5'd5, 1'b1, 5'd2, 1'b0, 5'd0}); end
      n_chk++; if (bubbleCount !== 16'd0) begin
        n_fail++; $display("FAIL stall_count_%0d got %0h exp 0", i, bubbleCount); end
    end
    stall = 1'b0;
    tick();
    n_chk++; if ({exValid, memDestReg, wbValid, wbDestReg, bubbleCount} !== {1'b0, 5'd5, 1'b1, 5'd2, 16'd1}) begin
      n_fail++; $display("FAIL stall_release_bubble got %0h exp %0h", {exValid, memDestReg, wbValid, wbDestReg, bubbleCount}, {1'b0, 5'd5, 1'b1, 5'd2, 16'd1}); end
    tick();
    n_chk++; if ({exValid, exDestReg, bubbleCount} !== {1'b1, 5'd6, 16'd1}) begin
      n_fail++; $display("FAIL stall_release_dep got %0h exp %0h", {exValid, exDestReg, bubbleCount}, {1'b1, 5'd6, 16'd1}); end
  endtask

  task automatic test_saturation();
    do_reset();
    // self-dependent load: alternates enter / hazard every two cycles
    set_id(1'b1, 2'b11, 3'b001, 4'h0, 5'd5, 5'd5, 5'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();  // hazard
      tick();  // enters EX again
      if (i == 5) begin
        n_chk++; if (s_bubbleCount !== 3'd6) begin
          n_fail++; $display("FAIL sat_preload got %0h exp 6", s_bubbleCount); end
      end
    end
    n_chk++; if (s_bubbleCount !== 3'd7) begin
      n_fail++; $display("FAIL sat_hold got %0h exp 7", s_bubbleCount); end
    n_chk++; if (bubbleCount !== 16'd8) begin
      n_fail++; $display("FAIL sat_wide_count got %0h exp 8", bubbleCount); end
    // reset wins over stall
    stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({exValid, exCalculation, exMemAccess, exWriteBack, exDestReg, memValid, memMemAccess, memWriteBack, memDestReg, wbValid, wbWriteBack, wbDestReg} !== 34'd0) begin
      n_fail++; $display("FAIL rst_stall_stages got %0h exp 0", {exValid, exCalculation, exMemAccess, exWriteBack, exDestReg, memValid, memMemAccess, memWriteBack, memDestReg, wbValid, wbWriteBack, wbDestReg}); end
    n_chk++; if ({bubbleCount, s_bubbleCount} !== 19'd0) begin
      n_fail++; $display("FAIL rst_stall_count got %0h exp 0", {bubbleCount, s_bubbleCount}); end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 2'b00, 3'b000, 4'h0, 5'd0, 5'd0, 5'd0);
    #1;
    test_reset();
    test_straight();
    test_load_use();
    test_dest_zero();
    test_flush();
    test_stall_hazard();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
